// File: rtl/fb_port_arbiter_pkg.sv
// Shared definitions for the frame-buffer port arbiter: FSM encoding, default
// port widths and the bit layout of one packed upper/lower RGB pixel pair.
package fb_port_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 48;

  localparam int PIXEL_BITS      = 8;
  localparam int UPPER_R_OFFSET  = 40;
  localparam int UPPER_G_OFFSET  = 32;
  localparam int UPPER_B_OFFSET  = 24;
  localparam int LOWER_R_OFFSET  = 16;
  localparam int LOWER_G_OFFSET  = 8;
  localparam int LOWER_B_OFFSET  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2
  } arbState_e;

  typedef struct packed {
    logic [PIXEL_BITS-1:0] upperR;
    logic [PIXEL_BITS-1:0] upperG;
    logic [PIXEL_BITS-1:0] upperB;
    logic [PIXEL_BITS-1:0] lowerR;
    logic [PIXEL_BITS-1:0] lowerG;
    logic [PIXEL_BITS-1:0] lowerB;
  } pixelPair_t;

  function automatic pixelPair_t unpackPair(input logic [DEF_DATA_WIDTH-1:0] raw);
    return pixelPair_t'(raw);
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO that buffers loader writes ({address, data}) until the
// scanner leaves a free RAM cycle. Head entry is visible combinationally.
module fb_wr_fifo #(
  parameter int WIDTH = 63,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wrData_i,
  output logic [WIDTH-1:0]         rdData_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign doPush   = push_i && !full_o;
  assign doPop    = pop_i && !empty_o;
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rdData_o = mem_q[rdPtr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wrData_i;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates one single-port image RAM between the display scanner (absolute
// priority, fixed 2-cycle read latency) and a buffered loader write stream.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 64
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic                  scan_valid,
  output logic [DATA_WIDTH-1:0] scan_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  wr_starved,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int ENTRY_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arbState_e             state_q;
  logic [ADDR_WIDTH-1:0] ramAddr_q;
  logic                  ramWe_q;
  logic [DATA_WIDTH-1:0] ramWdata_q;
  logic [1:0]            readPipe_q;
  logic                  flushDone_q;
  logic [STARVE_W-1:0]   starveCnt_q;
  logic                  starved_q;

  logic [ENTRY_W-1:0]    headEntry;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [DATA_WIDTH-1:0] headData;
  logic [CNT_W-1:0]      fifoCount;
  logic [CNT_W-1:0]      countNext_d;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  doPush;
  logic                  doPop;
  logic                  drainActive;
  logic                  blocked;

  fb_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i    (clk_in),
    .rst_i    (rst),
    .push_i   (doPush),
    .pop_i    (doPop),
    .wrData_i ({wr_addr, wr_data}),
    .rdData_o (headEntry),
    .count_o  (fifoCount),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty)
  );

  assign {headAddr, headData} = headEntry;

  // A full FIFO pops before it can accept, so ready depends only on registered state.
  assign wr_ready    = !fifoFull && (state_q != ST_DRAIN);
  assign doPush      = wr_valid && wr_ready;
  assign doPop       = !scan_req && !fifoEmpty;
  assign countNext_d = fifoCount + CNT_W'(doPush) - CNT_W'(doPop);
  assign drainActive = flush || (state_q == ST_DRAIN);
  assign blocked     = scan_req && !fifoEmpty;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ramAddr_q   <= '0;
      ramWe_q     <= 1'b0;
      ramWdata_q  <= '0;
      readPipe_q  <= '0;
      flushDone_q <= 1'b0;
      starveCnt_q <= '0;
      starved_q   <= 1'b0;
    end else begin
      ramWe_q     <= 1'b0;
      flushDone_q <= 1'b0;
      readPipe_q  <= {readPipe_q[0], scan_req};

      if (scan_req) begin
        ramAddr_q <= scan_addr;
      end else if (doPop) begin
        ramAddr_q  <= headAddr;
        ramWdata_q <= headData;
        ramWe_q    <= 1'b1;
      end

      // Drain ends in the cycle whose pop leaves the FIFO empty.
      if (drainActive) begin
        if (countNext_d == '0) begin
          flushDone_q <= 1'b1;
          state_q     <= ST_IDLE;
        end else begin
          state_q     <= ST_DRAIN;
        end
      end else begin
        case (state_q)
          ST_IDLE:  if (scan_req || !fifoEmpty) state_q <= ST_SERVE;
          ST_SERVE: if (!scan_req && fifoEmpty) state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end

      if (doPop) begin
        starveCnt_q <= '0;
      end else if (blocked && (starveCnt_q != STARVE_LIM)) begin
        starveCnt_q <= starveCnt_q + STARVE_W'(1);
      end

      if (blocked && (starveCnt_q == STARVE_LIM - STARVE_W'(1))) starved_q <= 1'b1;
    end
  end

  assign ram_addr   = ramAddr_q;
  assign ram_we     = ramWe_q;
  assign ram_wdata  = ramWdata_q;
  assign scan_valid = readPipe_q[1];
  assign scan_data  = ram_rdata;
  assign flush_done = flushDone_q;
  assign wr_starved = starved_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural single-port RAM whose
// read data appears one cycle after the address.
module tb_fb_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 48;

  logic          clk_in;
  logic          rst;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          flush;
  logic          flush_done;
  logic          wr_starved;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          memInit;
  int            checks;
  int            errors;

  fb_port_arbiter dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flush      (flush),
    .flush_done (flush_done),
    .wr_starved (wr_starved),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {9'h1A5, a, 9'h0C3, a};
  endfunction

  // Read-first synchronous RAM; preloaded with a per-address pattern while memInit is high.
  always @(posedge clk_in) begin
    if (memInit) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(AW'(i));
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    scan_req = 1'b0; scan_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    flush = 1'b0; memInit = 1'b1; rst = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    memInit = 1'b0;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we: got %0h expected 0", ram_we); end
    checks++; if (ram_addr !== '0) begin errors++; $display("[TB] FAIL reset_ram_addr: got %0h expected 0", ram_addr); end
    checks++; if (ram_wdata !== '0) begin errors++; $display("[TB] FAIL reset_ram_wdata: got %0h expected 0", ram_wdata); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_scan_valid: got %0h expected 0", scan_valid); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_done: got %0h expected 0", flush_done); end
    checks++; if (wr_starved !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_starved: got %0h expected 0", wr_starved); end
    rst = 1'b0;
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready: got %0h expected 1", wr_ready); end
  endtask

  task automatic test_scan_stream();
    int validRun;
    logic expValid;
    validRun = 0;
    for (int i = 0; i < 66; i++) begin
      scan_req = (i < 64);
      if (i < 64) scan_addr = AW'(i);
      tick();
      if (i < 64) begin
        checks++;
        if (ram_addr !== AW'(i) || ram_we !== 1'b0) begin
          errors++; $display("[TB] FAIL scan_port i=%0d: got addr %0h we %0h expected addr %0h we 0", i, ram_addr, ram_we, i);
        end
      end
      expValid = (i >= 1) && (i <= 64);
      if (scan_valid === 1'b1) validRun++;
      checks++;
      if (scan_valid !== expValid) begin
        errors++; $display("[TB] FAIL scan_valid i=%0d: got %0h expected %0h", i, scan_valid, expValid);
      end
      if (expValid) begin
        checks++;
        if (scan_data !== pat(AW'(i - 1))) begin
          errors++; $display("[TB] FAIL scan_data i=%0d: got %h expected %h", i, scan_data, pat(AW'(i - 1)));
        end
      end
    end
    checks++; if (validRun != 64) begin errors++; $display("[TB] FAIL scan_valid_count: got %0d expected 64", validRun); end
  endtask

  task automatic test_idle_writes();
    scan_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = (i < 3);
      wr_addr  = AW'(32'h100 + i);
      wr_data  = 48'h0ABC00000000 + 48'(i);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_wr_ready i=%0d: got %0h expected 1", i, wr_ready); end
      tick();
      if (i >= 1) begin
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(32'h100 + i - 1) || ram_wdata !== 48'h0ABC00000000 + 48'(i - 1)) begin
          errors++; $display("[TB] FAIL idle_write i=%0d: got we %0h addr %0h data %h expected we 1 addr %0h", i, ram_we, ram_addr, ram_wdata, 32'h100 + i - 1);
        end
      end
    end
    wr_valid = 1'b0;
    tick();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL idle_write_end: got we %0h expected 0", ram_we); end
  endtask

  task automatic test_fifo_full();
    scan_req = 1'b1; scan_addr = AW'(32'h200);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(32'h300 + i);
      wr_data  = 48'h550000000000 + 48'(i);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready i=%0d: got %0h expected 1", i, wr_ready); end
      tick();
      checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_we i=%0d: got %0h expected 0", i, ram_we); end
    end
    wr_addr = AW'(32'h304); wr_data = 48'h550000000004;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %0h expected 0", wr_ready); end
    tick();
    checks++; if (ram_we !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_blocked: got we %0h ready %0h expected 0 0", ram_we, wr_ready); end
    scan_req = 1'b0;
    tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== AW'(32'h300) || ram_wdata !== 48'h550000000000) begin
      errors++; $display("[TB] FAIL full_first_pop: got we %0h addr %0h data %h expected 1 300 550000000000", ram_we, ram_addr, ram_wdata);
    end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_after_pop: got %0h expected 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_addr !== AW'(32'h301)) begin errors++; $display("[TB] FAIL full_pop1: got we %0h addr %0h expected 1 301", ram_we, ram_addr); end
    for (int j = 2; j < 5; j++) begin
      tick();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(32'h300 + j) || ram_wdata !== 48'h550000000000 + 48'(j)) begin
        errors++; $display("[TB] FAIL full_pop j=%0d: got we %0h addr %0h data %h expected addr %0h", j, ram_we, ram_addr, ram_wdata, 32'h300 + j);
      end
    end
    tick();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL full_drained: got we %0h expected 0", ram_we); end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (mem[32'h300 + j] !== 48'h550000000000 + 48'(j)) begin
        errors++; $display("[TB] FAIL full_ram j=%0d: got %h expected %h", j, mem[32'h300 + j], 48'h550000000000 + 48'(j));
      end
    end
  endtask

  task automatic test_flush_empty();
    checks++; if (flush_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty_pre: got %0h expected 0", flush_done); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (flush_done !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty_done: got %0h expected 1", flush_done); end
    tick();
    checks++; if (flush_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty_pulse: got %0h expected 0", flush_done); end
  endtask

  task automatic test_flush_full();
    scan_req = 1'b1; scan_addr = AW'(32'h040);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(32'h500 + i); wr_data = 48'h770000000000 + 48'(i);
      tick();
    end
    wr_valid = 1'b0; scan_req = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_ready: got %0h expected 0", wr_ready); end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(32'h500 + j)) begin
        errors++; $display("[TB] FAIL drain_write j=%0d: got we %0h addr %0h expected 1 %0h", j, ram_we, ram_addr, 32'h500 + j);
      end
      checks++;
      if (flush_done !== (j == 3)) begin
        errors++; $display("[TB] FAIL drain_done j=%0d: got %0h expected %0h", j, flush_done, (j == 3));
      end
    end
    tick();
    checks++;
    if (flush_done !== 1'b0 || ram_we !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL drain_after: got done %0h we %0h ready %0h expected 0 0 1", flush_done, ram_we, wr_ready);
    end
  endtask

  task automatic test_raw_read();
    wr_valid = 1'b1; wr_addr = AW'(32'h0010); wr_data = 48'h123456ABCDEF;
    tick();
    wr_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (flush_done !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(32'h0010)) begin
      errors++; $display("[TB] FAIL raw_flush: got done %0h we %0h addr %0h expected 1 1 10", flush_done, ram_we, ram_addr);
    end
    scan_req = 1'b1; scan_addr = AW'(32'h0010);
    tick();
    scan_req = 1'b0;
    tick();
    checks++;
    if (scan_valid !== 1'b1 || scan_data !== 48'h123456ABCDEF) begin
      errors++; $display("[TB] FAIL raw_read: got valid %0h data %h expected 1 123456abcdef", scan_valid, scan_data);
    end
  endtask

  task automatic test_starvation();
    checks++; if (wr_starved !== 1'b0) begin errors++; $display("[TB] FAIL starve_pre: got %0h expected 0", wr_starved); end
    scan_req = 1'b1; scan_addr = AW'(32'h020);
    wr_valid = 1'b1; wr_addr = AW'(32'h400); wr_data = 48'h990000000000;
    tick();
    wr_addr = AW'(32'h401); wr_data = 48'h990000000001;
    tick();
    wr_valid = 1'b0;
    for (int j = 0; j < 62; j++) begin
      tick();
      checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL starve_no_we j=%0d: got %0h expected 0", j, ram_we); end
    end
    checks++; if (wr_starved !== 1'b0) begin errors++; $display("[TB] FAIL starve_63: got %0h expected 0", wr_starved); end
    tick();
    checks++; if (wr_starved !== 1'b1) begin errors++; $display("[TB] FAIL starve_64: got %0h expected 1", wr_starved); end
    scan_req = 1'b0;
    tick();
    checks++; if (ram_we !== 1'b1 || ram_addr !== AW'(32'h400)) begin errors++; $display("[TB] FAIL starve_land0: got we %0h addr %0h expected 1 400", ram_we, ram_addr); end
    tick();
    checks++; if (ram_we !== 1'b1 || ram_addr !== AW'(32'h401)) begin errors++; $display("[TB] FAIL starve_land1: got we %0h addr %0h expected 1 401", ram_we, ram_addr); end
    tick();
    checks++; if (wr_starved !== 1'b1) begin errors++; $display("[TB] FAIL starve_sticky: got %0h expected 1", wr_starved); end
  endtask

  task automatic test_reset_mid_op();
    scan_req = 1'b1; scan_addr = AW'(32'h050);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(32'h600 + i); wr_data = 48'h660000000000 + 48'(i);
      tick();
    end
    wr_valid = 1'b0;
    tick();
    scan_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
      errors++; $display("[TB] FAIL midrst_ram: got we %0h addr %0h data %h expected 0 0 0", ram_we, ram_addr, ram_wdata);
    end
    checks++;
    if (scan_valid !== 1'b0 || flush_done !== 1'b0 || wr_starved !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_flags: got valid %0h done %0h starved %0h expected 0 0 0", scan_valid, flush_done, wr_starved);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ram_we !== 1'b0 || scan_valid !== 1'b0 || wr_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL midrst_after k=%0d: got we %0h valid %0h ready %0h expected 0 0 1", k, ram_we, scan_valid, wr_ready);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[32'h600 + i] !== pat(AW'(32'h600 + i))) begin
        errors++; $display("[TB] FAIL midrst_ram_untouched i=%0d: got %h expected %h", i, mem[32'h600 + i], pat(AW'(32'h600 + i)));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan_stream();
    test_idle_writes();
    test_fifo_full();
    test_flush_empty();
    test_flush_full();
    test_raw_read();
    test_starvation();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
